// File: rtl/triangle_vertex_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : triangle_vertex_ctrl_if
//  Purpose  : Vertex-update handshake bundle for triangle_vertex_ctrl.
//             A requester (master) offers one vertex write per beat. The
//             controller (slave) accepts it when upd_valid & upd_ready.
//  Signals  : upd_valid  master->slave  write request
//             upd_ready  slave->master  write accepted this cycle
//             upd_sel    master->slave  vertex index 0..2 (3 = consumed, ignored)
//             upd_x      master->slave  new x coordinate (11 bits)
//             upd_y      master->slave  new y coordinate (10 bits)
//  Revision : 1.0  initial release
// ============================================================================
interface triangle_vertex_ctrl_if;
  logic        upd_valid;
  logic        upd_ready;
  logic [1:0]  upd_sel;
  logic [10:0] upd_x;
  logic [9:0]  upd_y;

  modport master (output upd_valid, output upd_sel, output upd_x, output upd_y,
                  input  upd_ready);
  modport slave  (input  upd_valid, input  upd_sel, input  upd_x, input  upd_y,
                  output upd_ready);
endinterface
`default_nettype wire

// File: rtl/triangle_vertex_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : triangle_vertex_ctrl
//  Purpose  : Frame-synchronous vertex configurator for the raster triangle
//             test. Writes land in shadow registers and are committed only at
//             the raster frame wrap, so the triangle never tears. Optionally
//             slides the triangle horizontally, bouncing off X_MIN/X_MAX.
//  Ports    : CLOCK_50    pixel clock, rising edge
//             reset       asynchronous active-high reset
//             cx, cy      raster counters (frame wrap at H_TOTAL-1, V_TOTAL-1)
//             upd         vertex write handshake (slave side)
//             anim_en     enable horizontal bounce animation
//             vx0..vy2    committed vertices (x includes animation offset)
//             frame_sync  one-cycle pulse when new vertices first appear
//             pending     a write was accepted since the last commit
//  Revision : 1.0  initial release
// ============================================================================
module triangle_vertex_ctrl #(
  parameter int H_TOTAL = 1586,
  parameter int V_TOTAL = 526,
  parameter int X_MIN   = 286,
  parameter int X_MAX   = 1554,
  parameter int STEP    = 2,
  parameter int V0X     = 286,
  parameter int V0Y     = 36,
  parameter int V1X     = 300,
  parameter int V1Y     = 300,
  parameter int V2X     = 1000,
  parameter int V2Y     = 500
) (
  input  wire logic               CLOCK_50,
  input  wire logic               reset,
  input  wire logic [10:0]        cx,
  input  wire logic [9:0]         cy,
  triangle_vertex_ctrl_if.slave   upd,
  input  wire logic               anim_en,
  output logic [10:0]             vx0,
  output logic [9:0]              vy0,
  output logic [10:0]             vx1,
  output logic [9:0]              vy1,
  output logic [10:0]             vx2,
  output logic [9:0]              vy2,
  output logic                    frame_sync,
  output logic                    pending
);

  localparam logic [1:0] c_st_active = 2'd0;
  localparam logic [1:0] c_st_commit = 2'd1;
  localparam logic [1:0] c_st_minmax = 2'd2;
  localparam logic [1:0] c_st_apply  = 2'd3;

  localparam logic [10:0]        c_h_last = 11'(H_TOTAL - 1);
  localparam logic [9:0]         c_v_last = 10'(V_TOTAL - 1);
  localparam logic signed [11:0] c_step   = 12'(STEP);
  localparam logic signed [12:0] c_x_min  = 13'(X_MIN);
  localparam logic signed [12:0] c_x_max  = 13'(X_MAX);
  localparam logic [10:0] c_rst_x [3] = '{11'(V0X), 11'(V1X), 11'(V2X)};
  localparam logic [9:0]  c_rst_y [3] = '{10'(V0Y), 10'(V1Y), 10'(V2Y)};

  logic [1:0]         r_state, w_state_nxt;
  logic               w_fw, w_ready, w_accept;
  logic               w_commit, w_minmax, w_apply;
  logic [10:0]        r_sh_x [3];
  logic [9:0]         r_sh_y [3];
  logic [10:0]        r_bs_x [3];
  logic [9:0]         r_bs_y [3];
  logic [10:0]        r_xmin, r_xmax, w_xmin, w_xmax;
  logic signed [11:0] r_cand, r_off, w_off_nxt;
  logic               r_dir, w_dir_nxt;
  logic signed [12:0] w_lo, w_hi;
  logic               w_base_bad, w_hit;

  assign w_fw     = (cx == c_h_last) && (cy == c_v_last);
  assign w_accept = upd.upd_valid && w_ready;
  assign upd.upd_ready = w_ready;

  // State register
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) r_state <= c_st_active;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_active: if (w_fw) w_state_nxt = c_st_commit;
      c_st_commit: w_state_nxt = c_st_minmax;
      c_st_minmax: w_state_nxt = c_st_apply;
      default:     w_state_nxt = c_st_active;
    endcase
  end

  // FSM outputs: handshake ready and per-phase strobes
  always_comb begin
    w_ready  = (r_state == c_st_active) && !w_fw;
    w_commit = (r_state == c_st_commit);
    w_minmax = (r_state == c_st_minmax);
    w_apply  = (r_state == c_st_apply);
  end

  // Horizontal extent of the committed base triangle
  always_comb begin
    w_xmin = r_bs_x[0];
    w_xmax = r_bs_x[0];
    for (int i = 1; i < 3; i++) begin
      if (r_bs_x[i] < w_xmin) w_xmin = r_bs_x[i];
      if (r_bs_x[i] > w_xmax) w_xmax = r_bs_x[i];
    end
  end

  // Bounds are evaluated one bit wider than the offset so the sums never wrap
  always_comb begin
    w_lo       = $signed({2'b00, r_xmin}) + 13'(r_cand);
    w_hi       = $signed({2'b00, r_xmax}) + 13'(r_cand);
    w_base_bad = ($signed({2'b00, r_xmin}) < c_x_min) || ($signed({2'b00, r_xmax}) > c_x_max);
    w_hit      = (w_lo < c_x_min) || (w_hi > c_x_max);
    w_off_nxt  = r_off;
    w_dir_nxt  = r_dir;
    if (anim_en) begin
      if (w_base_bad)  w_off_nxt = '0;     // base alone is out of range: recentre
      else if (w_hit)  w_dir_nxt = ~r_dir; // bounce, hold position this frame
      else             w_off_nxt = r_cand;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        r_sh_x[i] <= c_rst_x[i];
        r_sh_y[i] <= c_rst_y[i];
        r_bs_x[i] <= c_rst_x[i];
        r_bs_y[i] <= c_rst_y[i];
      end
      r_xmin     <= '0;
      r_xmax     <= '0;
      r_cand     <= '0;
      r_off      <= '0;
      r_dir      <= 1'b1;
      vx0        <= c_rst_x[0];
      vy0        <= c_rst_y[0];
      vx1        <= c_rst_x[1];
      vy1        <= c_rst_y[1];
      vx2        <= c_rst_x[2];
      vy2        <= c_rst_y[2];
      frame_sync <= 1'b0;
      pending    <= 1'b0;
    end else begin
      frame_sync <= w_apply;

      if (w_accept) begin
        for (int i = 0; i < 3; i++) begin
          if (upd.upd_sel == 2'(i)) begin
            r_sh_x[i] <= upd.upd_x;
            r_sh_y[i] <= upd.upd_y;
          end
        end
      end

      if (w_commit) begin
        pending <= 1'b0;
        for (int i = 0; i < 3; i++) begin
          r_bs_x[i] <= r_sh_x[i];
          r_bs_y[i] <= r_sh_y[i];
        end
      end else if (w_accept && (upd.upd_sel != 2'd3)) begin
        pending <= 1'b1;
      end

      if (w_minmax) begin
        r_xmin <= w_xmin;
        r_xmax <= w_xmax;
        r_cand <= r_dir ? (r_off + c_step) : (r_off - c_step);
      end

      if (w_apply) begin
        r_off <= w_off_nxt;
        r_dir <= w_dir_nxt;
        vx0   <= r_bs_x[0] + w_off_nxt[10:0];
        vx1   <= r_bs_x[1] + w_off_nxt[10:0];
        vx2   <= r_bs_x[2] + w_off_nxt[10:0];
        vy0   <= r_bs_y[0];
        vy1   <= r_bs_y[1];
        vy2   <= r_bs_y[2];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_triangle_vertex_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_triangle_vertex_ctrl
//  Purpose  : Self-checking bench for triangle_vertex_ctrl. Drives raster
//             counters directly (jumping to the frame wrap), randomised vertex
//             writes and animation, and compares every cycle against a
//             frame-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_triangle_vertex_ctrl;
  localparam int H_TOTAL = 1586;
  localparam int V_TOTAL = 526;
  localparam int X_MIN   = 286;
  localparam int X_MAX   = 1554;
  localparam int STEP    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] cx = '0;
  logic [9:0]  cy = '0;
  logic        anim_en = 1'b0;
  logic [10:0] vx0, vx1, vx2;
  logic [9:0]  vy0, vy1, vy2;
  logic        frame_sync, pending;

  triangle_vertex_ctrl_if upd_if ();

  triangle_vertex_ctrl dut (
    .CLOCK_50   (clk),
    .reset      (rst),
    .cx         (cx),
    .cy         (cy),
    .upd        (upd_if.slave),
    .anim_en    (anim_en),
    .vx0        (vx0),
    .vy0        (vy0),
    .vx1        (vx1),
    .vy1        (vy1),
    .vx2        (vx2),
    .vy2        (vy2),
    .frame_sync (frame_sync),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: shadow, committed base, visible outputs, animation state
  int sh_x[3], sh_y[3], bs_x[3], bs_y[3], out_x[3], out_y[3];
  int m_off;
  bit m_dir, m_fs, m_pend;
  int busy;  // cycles of frame processing still to run after the wrap

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    sh_x = '{286, 300, 1000};
    sh_y = '{36, 300, 500};
    bs_x = sh_x; bs_y = sh_y; out_x = sh_x; out_y = sh_y;
    m_off = 0; m_dir = 1'b1; m_fs = 1'b0; m_pend = 1'b0; busy = 0;
  endtask

  // Whole-frame update: animation rules applied to the committed triangle
  task automatic model_frame();
    int xmin, xmax, cand;
    xmin = bs_x[0]; xmax = bs_x[0];
    for (int i = 1; i < 3; i++) begin
      if (bs_x[i] < xmin) xmin = bs_x[i];
      if (bs_x[i] > xmax) xmax = bs_x[i];
    end
    cand = m_off + (m_dir ? STEP : -STEP);
    if (anim_en) begin
      if (xmin < X_MIN || xmax > X_MAX)                   m_off = 0;
      else if (xmin + cand < X_MIN || xmax + cand > X_MAX) m_dir = !m_dir;
      else                                                 m_off = cand;
    end
    for (int i = 0; i < 3; i++) begin
      out_x[i] = (bs_x[i] + m_off) & 2047;
      out_y[i] = bs_y[i];
    end
  endtask

  task automatic check_outputs();
    check("vx0", vx0, out_x[0]); check("vy0", vy0, out_y[0]);
    check("vx1", vx1, out_x[1]); check("vy1", vy1, out_y[1]);
    check("vx2", vx2, out_x[2]); check("vy2", vy2, out_y[2]);
    check("frame_sync", frame_sync, m_fs);
    check("pending", pending, m_pend);
  endtask

  // One clock: drive at negedge, check ready, advance model at posedge, check outputs
  task automatic step(input logic [10:0] x_c, input logic [9:0] y_c, input logic v,
                      input logic [1:0] s, input logic [10:0] ux, input logic [9:0] uy);
    bit fw, rdy, acc;
    cx = x_c; cy = y_c;
    upd_if.upd_valid = v; upd_if.upd_sel = s; upd_if.upd_x = ux; upd_if.upd_y = uy;
    fw  = (int'(x_c) == H_TOTAL - 1) && (int'(y_c) == V_TOTAL - 1);
    rdy = (busy == 0) && !fw;
    #1;
    check("upd_ready", upd_if.upd_ready, rdy);
    acc = v && rdy;
    @(posedge clk);
    m_fs = 1'b0;
    if (busy == 0) begin
      if (acc && s != 2'd3) begin
        sh_x[s] = ux; sh_y[s] = uy; m_pend = 1'b1;
      end
      if (fw) busy = 3;
    end else begin
      if (busy == 3) begin
        bs_x = sh_x; bs_y = sh_y; m_pend = 1'b0;
      end
      if (busy == 1) begin
        model_frame();
        m_fs = 1'b1;
      end
      busy--;
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();
    step(11'($urandom_range(0, H_TOTAL - 2)), 10'($urandom_range(0, V_TOTAL - 1)),
         1'b0, 2'd0, 11'd0, 10'd0);
  endtask

  task automatic wrap(input logic v);
    step(11'(H_TOTAL - 1), 10'(V_TOTAL - 1), v, 2'd0, 11'd123, 10'd45);
  endtask

  task automatic rnd_write();
    logic [10:0] x;
    if ($urandom_range(0, 7) == 0) x = 11'($urandom_range(0, 2047));
    else                           x = 11'($urandom_range(X_MIN, X_MAX));
    step(11'($urandom_range(0, H_TOTAL - 2)), 10'($urandom_range(0, V_TOTAL - 1)),
         1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), x, 10'($urandom));
  endtask

  // n_act active cycles, the wrap, then the three processing cycles
  task automatic frame(input int n_act, input bit rnd);
    for (int i = 0; i < n_act; i++) begin
      if (rnd) rnd_write(); else idle();
    end
    wrap(rnd ? 1'($urandom_range(0, 1)) : 1'b0);
    for (int i = 0; i < 3; i++) begin
      if (rnd) rnd_write(); else idle();
    end
  endtask

  // Asynchronous reset asserted between clock edges
  task automatic do_reset();
    cx = 11'd0; cy = 10'd0; upd_if.upd_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    check("upd_ready_rst", upd_if.upd_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    upd_if.upd_valid = 1'b0; upd_if.upd_sel = 2'd0; upd_if.upd_x = '0; upd_if.upd_y = '0;
    model_reset();
    @(negedge clk);
    check_outputs();
    check("upd_ready_rst", upd_if.upd_ready, 1'b1);
    rst = 1'b0;

    // Tearing: write vertex 1 mid-frame, visible only after the wrap
    step(11'd500, 10'd100, 1'b1, 2'd1, 11'd400, 10'd200);
    for (int i = 0; i < 4; i++) idle();
    frame(2, 1'b0);
    check("vx1_committed", vx1, 11'd400);

    // Handshake held across the wrap: accepted in the first ACTIVE cycle
    idle();
    step(11'(H_TOTAL - 1), 10'(V_TOTAL - 1), 1'b1, 2'd2, 11'd700, 10'd250);
    for (int i = 0; i < 4; i++) step(11'd10, 10'd0, 1'b1, 2'd2, 11'd700, 10'd250);
    frame(3, 1'b0);

    // Ignored select: consumed, nothing changes
    step(11'd20, 10'd5, 1'b1, 2'd3, 11'd1500, 10'd9);
    frame(2, 1'b0);

    // Reset in the middle of frame processing discards the commit
    step(11'd30, 10'd7, 1'b1, 2'd0, 11'd900, 10'd400);
    wrap(1'b0);
    idle();
    do_reset();

    // Randomised traffic with random animation per frame
    for (int f = 0; f < 40; f++) begin
      anim_en = 1'($urandom_range(0, 1));
      frame($urandom_range(1, 6), 1'b1);
    end

    // Animation from defaults: right bounce, then left bounce with vertex 0 at 287
    do_reset();
    anim_en = 1'b1;
    for (int f = 0; f < 400 && m_dir; f++) frame(1, 1'b0);
    step(11'd40, 10'd3, 1'b1, 2'd0, 11'd287, 10'd36);
    for (int f = 0; f < 400 && !m_dir; f++) frame(1, 1'b0);
    for (int f = 0; f < 5; f++) frame(1, 1'b0);
    anim_en = 1'b0;
    for (int f = 0; f < 3; f++) frame(1, 1'b0);
    anim_en = 1'b1;
    for (int f = 0; f < 3; f++) frame(1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
